// File: rtl/fluidic_path_scheduler_pkg.sv
// Shared types and elaboration-time parameter checks for the fluidic path scheduler.
package fluidic_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PROCESS,
    S_MIX,
    S_DETECT
  } state_t;

  function automatic logic cyc_ok(input int unsigned cyc);
    return cyc >= 1;
  endfunction

  // A phase of length cyc is counted down from cyc-1, so cyc-1 must fit in w bits.
  function automatic logic cnt_fits(input int unsigned cyc, input int unsigned w);
    return (w >= 32) || (((cyc - 1) >> w) == 0);
  endfunction

  function automatic logic timeout_ok(input int unsigned t, input int unsigned w);
    return (t >= 1) && ((w >= 32) || ((t >> w) == 0));
  endfunction

endpackage

// File: rtl/fluidic_path_scheduler_if.sv
// Host/actuator signal bundle of the fluidic path scheduler.
interface fluidic_path_scheduler_if #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 8
);
  logic                    start;
  logic [N_CH-1:0]         branch_mask;
  logic [N_CH*CNT_W-1:0]   dwell;
  logic                    det_valid;
  logic [DATA_W-1:0]       det_data;
  logic                    inlet_open;
  logic [N_CH-1:0]         branch_valve;
  logic                    mix_en;
  logic                    det_req;
  logic [DATA_W-1:0]       result;
  logic                    busy;
  logic                    done;
  logic                    timeout_err;

  modport master (
    output start, branch_mask, dwell, det_valid, det_data,
    input  inlet_open, branch_valve, mix_en, det_req, result, busy, done, timeout_err
  );

  modport slave (
    input  start, branch_mask, dwell, det_valid, det_data,
    output inlet_open, branch_valve, mix_en, det_req, result, busy, done, timeout_err
  );
endinterface

// File: rtl/fluidic_path_scheduler_dwell_counter.sv
// Per-branch dwell down-counter; active while the remaining dwell is nonzero.
module dwell_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_en,
  output logic             o_active,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_active = (r_count != '0);
  assign o_count  = r_count;
endmodule

// File: rtl/fluidic_path_scheduler.sv
// Timed sequencer: inlet fill, per-branch dwell, mix, then detector handshake with timeout.
module fluidic_path_scheduler
  import fluidic_sched_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FILL_CYC = 16,
  parameter int unsigned MIX_CYC  = 32,
  parameter int unsigned TIMEOUT  = 200
) (
  input logic                   clk,
  input logic                   rst,
  fluidic_path_scheduler_if.slave bus
);

  if (!cyc_ok(FILL_CYC) || !cyc_ok(MIX_CYC)) begin : g_chk_cyc
    $error("fluidic_path_scheduler: FILL_CYC and MIX_CYC must be >= 1");
  end
  if (!cnt_fits(FILL_CYC, CNT_W) || !cnt_fits(MIX_CYC, CNT_W)) begin : g_chk_fit
    $error("fluidic_path_scheduler: FILL_CYC/MIX_CYC exceed the CNT_W counter");
  end
  if (!timeout_ok(TIMEOUT, CNT_W)) begin : g_chk_tmo
    $error("fluidic_path_scheduler: TIMEOUT must be in 1..2**CNT_W-1");
  end

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_inlet_open;
  logic [N_CH-1:0]    r_branch_valve;
  logic               r_mix_en;
  logic               r_det_req;
  logic [DATA_W-1:0]  r_result;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout_err;

  logic               w_accept;
  logic               w_dwell_en;
  logic               w_any_dwell;
  logic [N_CH-1:0]    w_active;
  logic [CNT_W-1:0]   w_count [N_CH];

  assign w_accept = (r_state == S_IDLE) && bus.start && (|bus.branch_mask);

  // Counters start decrementing on the last FILL cycle so each counter value
  // predicts the registered valve state of the following cycle.
  assign w_dwell_en = (r_state == S_PROCESS) || ((r_state == S_FILL) && (r_cnt == '0));

  for (genvar i = 0; i < N_CH; i++) begin : g_branch
    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_value  (bus.branch_mask[i] ? bus.dwell[i*CNT_W +: CNT_W] : '0),
      .i_en     (w_dwell_en),
      .o_active (w_active[i]),
      .o_count  (w_count[i])
    );
  end

  always_comb begin
    w_any_dwell = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_any_dwell = w_any_dwell | (|w_count[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_inlet_open   <= 1'b0;
      r_branch_valve <= '0;
      r_mix_en       <= 1'b0;
      r_det_req      <= 1'b0;
      r_result       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state        <= S_FILL;
            r_cnt          <= CNT_W'(FILL_CYC - 1);
            r_inlet_open   <= 1'b1;
            r_branch_valve <= bus.branch_mask;
            r_busy         <= 1'b1;
            r_timeout_err  <= 1'b0;
          end
        end
        S_FILL: begin
          if (r_cnt == '0) begin
            r_state        <= S_PROCESS;
            r_inlet_open   <= 1'b0;
            r_branch_valve <= w_active;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PROCESS: begin
          if (!w_any_dwell) begin
            r_state        <= S_MIX;
            r_cnt          <= CNT_W'(MIX_CYC - 1);
            r_branch_valve <= '0;
            r_mix_en       <= 1'b1;
          end else begin
            r_branch_valve <= w_active;
          end
        end
        S_MIX: begin
          if (r_cnt == '0) begin
            r_state   <= S_DETECT;
            r_cnt     <= CNT_W'(TIMEOUT - 1);
            r_mix_en  <= 1'b0;
            r_det_req <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DETECT: begin
          if (bus.det_valid) begin
            r_state   <= S_IDLE;
            r_result  <= bus.det_data;
            r_det_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state       <= S_IDLE;
            r_timeout_err <= 1'b1;
            r_det_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inlet_open   = r_inlet_open;
  assign bus.branch_valve = r_branch_valve;
  assign bus.mix_en       = r_mix_en;
  assign bus.det_req      = r_det_req;
  assign bus.result       = r_result;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_fluidic_path_scheduler.sv
// Directed bench for fluidic_path_scheduler: timeline model per cycle plus result scoreboard.
module tb_fluidic_path_scheduler;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 8;
  localparam int FILL = 4;
  localparam int MIX  = 3;
  localparam int TMO  = 10;

  typedef struct {
    logic [7:0] result;
    logic       terr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fluidic_path_scheduler_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DATA_W(DW)) bus ();

  fluidic_path_scheduler #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DATA_W(DW),
    .FILL_CYC(FILL), .MIX_CYC(MIX), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb[$];
  logic [7:0] model_result = 8'h00;
  logic       model_terr   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic inl, input logic [2:0] vlv, input logic mx,
                          input logic dr, input logic [7:0] res, input logic bsy, input logic dn,
                          input logic te);
    chk({tag, " inlet"},  bus.inlet_open,   inl);
    chk({tag, " valve"},  bus.branch_valve, vlv);
    chk({tag, " mix"},    bus.mix_en,       mx);
    chk({tag, " detreq"}, bus.det_req,      dr);
    chk({tag, " result"}, bus.result,       res);
    chk({tag, " busy"},   bus.busy,         bsy);
    chk({tag, " done"},   bus.done,         dn);
    chk({tag, " terr"},   bus.timeout_err,  te);
  endtask

  task automatic idle_cycles(input int n, input logic [2:0] mask_with_start);
    for (int k = 0; k < n; k++) begin
      bus.start       = (mask_with_start != 3'b000) || (k == 0);
      bus.branch_mask = mask_with_start;
      step();
      chk_outs($sformatf("idle%0d", k), 1'b0, 3'b000, 1'b0, 1'b0, model_result, 1'b0, 1'b0, model_terr);
      bus.start = 1'b0;
    end
  endtask

  // Start a run in the current cycle (cycle 0) and check every cycle through the done cycle.
  // v < 0 means no detector reading; ign_c drives an extra start, noise_c a stray det_valid.
  task automatic run(input string tag, input logic [2:0] m, input int d0, input int d1, input int d2,
                     input int v, input logic [7:0] data, input int ign_c, input int noise_c);
    int d[3];
    int p, mix_s, det_s, endc;
    logic to;
    logic [7:0] newres;
    logic [2:0] vexp;
    exp_t e, got;
    d = '{d0, d1, d2};
    p = 1;
    for (int i = 0; i < 3; i++) if (m[i] && d[i] > p) p = d[i];
    mix_s = FILL + 1 + p;
    det_s = mix_s + MIX;
    if (v >= det_s && v < det_s + TMO) begin
      endc = v + 1; to = 1'b0; newres = data;
    end else begin
      endc = det_s + TMO; to = 1'b1; newres = model_result;
    end
    e.result = newres;
    e.terr   = to;
    sb.push_back(e);

    bus.start       = 1'b1;
    bus.branch_mask = m;
    bus.dwell       = {d2[7:0], d1[7:0], d0[7:0]};
    bus.det_valid   = 1'b0;
    for (int c = 1; c <= endc; c++) begin
      step();
      bus.start       = (c == ign_c);
      bus.branch_mask = (c == ign_c) ? 3'b010 : m;
      bus.det_valid   = (c == v) || (c == noise_c);
      bus.det_data    = (c == v) ? data : 8'h3C;
      for (int i = 0; i < 3; i++) begin
        if (c <= FILL) vexp[i] = m[i];
        else if (c < mix_s) vexp[i] = m[i] && ((c - FILL - 1) < d[i]);
        else vexp[i] = 1'b0;
      end
      if (bus.done === 1'b1) begin
        chk($sformatf("%s sb_nonempty", tag), sb.size() != 0, 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          chk($sformatf("%s sb_result", tag), bus.result, got.result);
          chk($sformatf("%s sb_terr", tag), bus.timeout_err, got.terr);
        end
      end
      if (c < endc)
        chk_outs($sformatf("%s c%0d", tag, c), c <= FILL, vexp, (c >= mix_s) && (c < det_s),
                 c >= det_s, model_result, 1'b1, 1'b0, 1'b0);
      else
        chk_outs($sformatf("%s c%0d end", tag, c), 1'b0, 3'b000, 1'b0, 1'b0, newres, 1'b0, 1'b1, to);
    end
    bus.start     = 1'b0;
    bus.det_valid = 1'b0;
    model_result  = newres;
    model_terr    = to;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.branch_mask = 3'b000;
    bus.dwell       = '0;
    bus.det_valid   = 1'b0;
    bus.det_data    = 8'h00;

    step();
    chk_outs("reset", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();

    // start with an empty mask must not leave IDLE
    idle_cycles(2, 3'b000);

    run("capture", 3'b111, 0, 2, 5, 15, 8'hA5, -1, 2);
    // back-to-back: start taken in the done cycle; start during MIX ignored
    run("timeout", 3'b111, 0, 2, 5, -1, 8'h00, 11, -1);
    idle_cycles(3, 3'b000);
    chk("sticky terr", bus.timeout_err, 1'b1);

    run("lastcyc", 3'b111, 0, 2, 5, 22, 8'h5A, -1, -1);
    idle_cycles(1, 3'b000);
    run("zerodwell", 3'b101, 0, 7, 0, 9, 8'h11, 7, -1);
    idle_cycles(1, 3'b000);
    run("settimeout", 3'b010, 9, 3, 9, -1, 8'h00, -1, -1);

    // reset mid-PROCESS, asynchronously within cycle 7
    bus.start       = 1'b1;
    bus.branch_mask = 3'b111;
    bus.dwell       = {8'd5, 8'd2, 8'd0};
    for (int c = 1; c <= 7; c++) begin
      step();
      bus.start = 1'b0;
    end
    chk("pre_rst valve", bus.branch_valve, 3'b100);
    chk("pre_rst busy", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    model_result = 8'h00;
    model_terr   = 1'b0;
    step();
    rst = 1'b0;
    step();

    run("post_rst", 3'b111, 0, 2, 5, 14, 8'hC3, -1, -1);
    idle_cycles(1, 3'b000);
    run("post_rst_to", 3'b001, 1, 0, 0, -1, 8'h00, -1, -1);
    run("clear_terr", 3'b011, 3, 1, 0, 12, 8'h7E, -1, -1);

    chk("sb drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fluidic_path_scheduler.md
# fluidic_path_scheduler

Clocked controller that sequences a parametrised set of parallel fluidic branches. The branches fan out from a common inlet, pass through per-branch process elements (chamber, filter, heater), merge at a mixer and terminate at a detector. It drives the inlet, branch valves and mixer, holds each branch for a programmable dwell, then handshakes with the detector and captures its reading. It is the timed successor of the static chamber/filter/heater/mixer/detector netlists and sits between the assay host and the valve/actuator drivers.

## Interface
- N_CH, 3, number of parallel branches
- CNT_W, 8, dwell/timeout counter width
- DATA_W, 8, detector data width
- FILL_CYC, 16, cycles inlet is open (≥1)
- MIX_CYC, 32, cycles mixer runs (≥1)
- TIMEOUT, 200, max DETECT cycles without det_valid (1..2**CNT_W-1)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled in IDLE only
- branch_mask  in  N_CH  branches enabled for this run
- dwell  in  N_CH*CNT_W  branch i dwell at [i*CNT_W +: CNT_W]
- det_valid  in  1  detector reading valid
- det_data  in  DATA_W  detector reading
- inlet_open  out  1  common inlet valve
- branch_valve  out  N_CH  per-branch valve
- mix_en  out  1  mixer enable
- det_req  out  1  detector request
- result  out  DATA_W  last captured reading
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- timeout_err  out  1  last run timed out; sticky until next accepted start

## Operation
- States: IDLE, FILL, PROCESS, MIX, DETECT.
- IDLE: start=1 with branch_mask≠0 → latch mask and dwells, clear timeout_err, go to FILL. start with mask=0 is ignored. start outside IDLE is ignored.
- FILL: inlet_open=1, branch_valve=latched mask, for FILL_CYC cycles, then PROCESS.
- PROCESS: inlet closed. branch_valve[i]=1 for dwell_i cycles if mask[i], else 0. Dwell 0 → valve low from the first PROCESS cycle. State length = max(1, max dwell over masked branches), then MIX.
- MIX: mix_en=1 for MIX_CYC cycles, all valves closed, then DETECT.
- DETECT: det_req=1. If det_valid is sampled high: result←det_data, done pulse, IDLE. If TIMEOUT DETECT cycles pass without det_valid: timeout_err=1, done pulse, result unchanged, IDLE. If det_valid arrives on the last allowed cycle, valid wins.
- det_valid outside DETECT is ignored.
- busy=1 in every state except IDLE.
- rst at any time: immediate return to IDLE; all outputs forced to 0.

## Timing
- All outputs registered. Reset value of every output is 0.
- start is sampled at cycle 0. inlet_open is high in cycles 1..FILL_CYC. PROCESS starts at cycle FILL_CYC+1.
- MIX immediately follows PROCESS with no gap. DETECT immediately follows MIX.
- det_valid sampled at cycle k → result updated, done=1 and busy=0 in cycle k+1. det_req low in cycle k+1.
- Back-to-back: start is accepted in the first IDLE cycle after done.

## Structure
- Package fluidic_sched_pkg holds:
  - the state enum typedef
  - parameter-check helpers, i.e. elaboration-time assertions that FILL_CYC, MIX_CYC ≥1 and TIMEOUT < 2**CNT_W.
- Sub-module dwell_counter holds the per-branch logic and is instantiated N_CH times via generate:
  - inputs load, value, en
  - outputs active (count≠0) and a count register.
- The FSM, the shared FILL/MIX/timeout counter and the output registers live in the top level.

## Test plan
- Bench parameters: N_CH=3, CNT_W=8, FILL_CYC=4, MIX_CYC=3, TIMEOUT=10. Cycle 0 is the start cycle.
- mask=111, dwells {b2=5, b1=2, b0=0}:
  - inlet high cycles 1–4
  - valve0 low from cycle 5
  - valve1 high cycles 5–6
  - valve2 high cycles 5–9
  - mix_en high cycles 10–12
  - det_req high from cycle 13
- Same run, det_valid=1 with det_data=0xA5 at cycle 15 → result=0xA5, done pulse and busy=0 at cycle 16, timeout_err=0.
- Same run, det_valid never asserted:
  - det_req high cycles 13–22
  - done=1 and timeout_err=1 at cycle 23
  - result keeps its prior value
  - det_valid asserted exactly at cycle 22 instead → capture, timeout_err=0.
- All dwells 0 with mask=101 → PROCESS lasts one cycle (cycle 5), mix_en cycles 6–8. Start with mask=000 → no state change. Start during MIX → ignored.
- rst asserted at cycle 7 mid-PROCESS:
  - all outputs 0 in the same cycle, asynchronously
  - after release, a new start runs the full sequence correctly
  - a following start clears a sticky timeout_err.
